// File: rtl/jtag_user_bridge.sv
// JTAG user-register command bridge: decodes 32-bit command words from the
// TAP user data register and runs single-beat reads/writes on a simple
// request/acknowledge register bus. The response word is held for the TAP
// to capture. Everything runs in the tck domain.
module jtag_user_bridge #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] RESET_RSP = 32'hE6712945
) (
  input  logic              tck,
  input  logic              rst,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [31:0]       rsp_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  // The counter only needs to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] OpNop     = 4'h0;
  localparam logic [3:0] OpSetAddr = 4'h1;
  localparam logic [3:0] OpWriteLo = 4'h2;
  localparam logic [3:0] OpWriteHi = 4'h3;
  localparam logic [3:0] OpRead    = 4'h4;
  localparam logic [3:0] OpStatus  = 4'h5;

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wlo_q, wlo_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_badop_q, err_badop_d;
  logic [31:0]       rsp_q, rsp_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [3:0]  opcode;
  logic [15:0] payload;
  logic        unused_cmd_bits;

  assign opcode          = cmd_data[31:28];
  assign payload         = cmd_data[15:0];
  assign unused_cmd_bits = ^cmd_data[27:16];

  assign cmd_ready = ready_q;
  assign rsp_data  = rsp_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  // State register with synchronous reset.
  always_ff @(posedge tck) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wlo_q         <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      err_badop_q   <= 1'b0;
      rsp_q         <= RESET_RSP;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      ready_q       <= 1'b1;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wlo_q         <= wlo_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      err_badop_q   <= err_badop_d;
      rsp_q         <= rsp_d;
      req_q         <= req_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      ready_q       <= ready_d;
      cnt_q         <= cnt_d;
    end
  end

  // Command decode, bus sequencing and timeout handling.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wlo_d         = wlo_q;
    err_timeout_d = err_timeout_q;
    err_overrun_d = err_overrun_q;
    err_badop_d   = err_badop_q;
    rsp_d         = rsp_q;
    req_d         = req_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    ready_d       = ready_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (opcode)
            OpNop: ;
            OpSetAddr: addr_d = payload[ADDR_W-1:0];
            OpWriteLo: wlo_d = payload;
            OpWriteHi: begin
              wdata_d = {payload, wlo_q};
              we_d    = 1'b1;
              req_d   = 1'b1;
              ready_d = 1'b0;
              cnt_d   = '0;
              state_d = StBus;
            end
            OpRead: begin
              we_d    = 1'b0;
              req_d   = 1'b1;
              ready_d = 1'b0;
              cnt_d   = '0;
              state_d = StBus;
            end
            OpStatus: begin
              rsp_d = {4'hA, 9'h0, err_timeout_q, err_overrun_q, err_badop_q, 16'(addr_q)};
              err_timeout_d = 1'b0;
              err_overrun_d = 1'b0;
              err_badop_d   = 1'b0;
            end
            default: err_badop_d = 1'b1;
          endcase
        end
      end
      StBus: begin
        // Commands arriving mid-transaction are dropped.
        if (cmd_valid) err_overrun_d = 1'b1;
        if (bus_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          if (!we_q) rsp_d = bus_rdata;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // This was the TIMEOUT-th cycle with req high and no ack.
          state_d       = StIdle;
          req_d         = 1'b0;
          we_d          = 1'b0;
          ready_d       = 1'b1;
          err_timeout_d = 1'b1;
          if (!we_q) rsp_d = 32'hFFFF_FFFF;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_jtag_user_bridge.sv
// Directed self-checking bench for jtag_user_bridge (TIMEOUT = 4).
module tb_jtag_user_bridge;

  logic        tck = 1'b0;
  logic        rst;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  jtag_user_bridge #(
    .ADDR_W   (16),
    .TIMEOUT  (4),
    .RESET_RSP(32'hE6712945)
  ) dut (
    .tck      (tck),
    .rst      (rst),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data (rsp_data),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 tck = ~tck;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle command pulse; on return the outputs show cycle N+1.
  task automatic send(input logic [31:0] cmd);
    cmd_data  = cmd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = '0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_data  = '0;
    cmd_valid = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rsp", rsp_data, 32'hE6712945);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);

    // Write 0x12345678 to 0x0040, ack in the third request cycle
    send(32'h1000_0040);
    send(32'h2000_5678);
    send(32'h3000_1234);
    chk("wr_req1", 32'(bus_req), 32'd1);
    chk("wr_we", 32'(bus_we), 32'd1);
    chk("wr_addr", 32'(bus_addr), 32'h0040);
    chk("wr_wdata", bus_wdata, 32'h1234_5678);
    chk("wr_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_req2", 32'(bus_req), 32'd1);
    tick();
    chk("wr_req3", 32'(bus_req), 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("wr_req_done", 32'(bus_req), 32'd0);
    chk("wr_ready_done", 32'(cmd_ready), 32'd1);
    chk("wr_rsp_kept", rsp_data, 32'hE6712945);
    send(32'h5000_0000);
    chk("wr_status", rsp_data, 32'hA000_0041);

    // Read at 0xFFFF, address wraps to 0
    send(32'h1000_FFFF);
    send(32'h4000_0000);
    chk("rd_req", 32'(bus_req), 32'd1);
    chk("rd_we", 32'(bus_we), 32'd0);
    chk("rd_addr", 32'(bus_addr), 32'h0000_FFFF);
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    chk("rd_rsp", rsp_data, 32'hCAFE_F00D);
    chk("rd_req_done", 32'(bus_req), 32'd0);
    send(32'h5000_0000);
    chk("rd_status_wrap", rsp_data, 32'hA000_0000);

    // Read timeout: req high exactly 4 cycles
    send(32'h4000_0000);
    chk("to_req1", 32'(bus_req), 32'd1);
    tick();
    tick();
    tick();
    chk("to_req4", 32'(bus_req), 32'd1);
    tick();
    chk("to_req_drop", 32'(bus_req), 32'd0);
    chk("to_rsp", rsp_data, 32'hFFFF_FFFF);
    chk("to_ready", 32'(cmd_ready), 32'd1);
    send(32'h5000_0000);
    chk("to_status1", rsp_data, 32'hA004_0000);
    send(32'h5000_0000);
    chk("to_status2", rsp_data, 32'hA000_0000);

    // Ack in the TIMEOUT-th cycle is a normal completion
    send(32'h1000_0010);
    send(32'h4000_0000);
    tick();
    tick();
    tick();
    chk("edge_req4", 32'(bus_req), 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    chk("edge_rsp", rsp_data, 32'h1234_5678);
    send(32'h5000_0000);
    chk("edge_status", rsp_data, 32'hA000_0011);

    // Overrun during BUS and a bad opcode in IDLE
    send(32'h1000_0020);
    send(32'h3000_ABCD);
    chk("ov_wdata", bus_wdata, 32'hABCD_5678);
    cmd_data  = 32'h1000_0005;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = '0;
    chk("ov_addr_held", 32'(bus_addr), 32'h0020);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("ov_rsp_kept", rsp_data, 32'hA000_0011);
    send(32'h9000_0000);
    chk("badop_ready", 32'(cmd_ready), 32'd1);
    send(32'h5000_0000);
    chk("ov_status", rsp_data, 32'hA003_0021);

    // Reset one cycle into a write; late ack ignored
    send(32'h1000_0007);
    send(32'h3000_1111);
    chk("rw_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req_low", 32'(bus_req), 32'd0);
    chk("rw_wdata", bus_wdata, 32'd0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("rw_late_req", 32'(bus_req), 32'd0);
    chk("rw_rsp", rsp_data, 32'hE6712945);
    chk("rw_ready", 32'(cmd_ready), 32'd1);
    send(32'h5000_0000);
    chk("rw_status", rsp_data, 32'hA000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
